// File: rtl/scan_mux.sv
// Registered N_CH x WIDTH multiplexer. The select comes either from a software
// load (manual) or from a round-robin scan that holds each channel DWELL cycles.
module scan_mux #(
  parameter int N_CH  = 16,
  parameter int WIDTH = 1,
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_CH*WIDTH-1:0]   data_in_i,
  input  logic [SEL_W-1:0]        sel_in_i,
  input  logic                    load_i,
  input  logic                    mode_i,
  input  logic                    en_i,
  output logic [WIDTH-1:0]        data_out_o,
  output logic [SEL_W-1:0]        cur_sel_o,
  output logic                    out_valid_o,
  output logic                    wrap_o,
  output logic                    sel_err_o
);

  localparam logic [15:0]      DWELL_LAST = 16'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] ch_data;
  logic             sel_legal;

  // Decode loop keeps the part-select index inside data_in_i even when
  // 2**SEL_W exceeds N_CH.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_q == SEL_W'(k)) ch_data = data_in_i[k*WIDTH +: WIDTH];
    end
  end

  assign sel_legal = (32'(sel_in_i) < 32'(N_CH));

  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (en_i) begin
      data_d  = ch_data;
      valid_d = 1'b1;
      if (mode_i) begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (sel_q == SEL_LAST) begin
            sel_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end else begin
        // Manual mode parks the dwell counter so a later scan starts fresh.
        cnt_d = '0;
        if (load_i) begin
          if (sel_legal) sel_d = sel_in_i;
          else           err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign data_out_o  = data_q;
  assign cur_sel_o   = sel_q;
  assign out_valid_o = valid_q;
  assign wrap_o      = wrap_q;
  assign sel_err_o   = err_q;

endmodule
